bht_arbiter: RTL and testbench

Sequencing controller for a single-port, synchronous-read branch history table (BHT) of 2-bit saturating counters. It shares the one table port between fetch-stage prediction lookups and commit-stage counter updates. It buffers updates in a small FIFO and performs each update as a two-cycle read-modify-write. It also clears the whole table after reset or on flush.

---
 rtl/bpb_pkg.sv | 24 ++
 rtl/bht_upd_fifo.sv | 51 +++++
 rtl/state_switch.sv | 20 ++
 rtl/bht_arbiter.sv | 139 +++++++++++++
 tb/tb_bht_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bpb_pkg.sv
// Shared types and constants for the branch prediction block.
// Used by the BHT arbiter, its update FIFO and the counter logic.
package bpb_pkg;

   localparam int BPB_E = 8;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      RMW_RD,
      RMW_WR
   } bht_state_e;

   localparam logic [1:0] CNT_STRONG_NT = 2'b00;
   localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
   localparam logic [1:0] CNT_WEAK_T    = 2'b10;
   localparam logic [1:0] CNT_STRONG_T  = 2'b11;

   typedef struct packed {
      logic [BPB_E-1:0] index;
      logic             taken;
   } bht_upd_t;

endpackage

// File: rtl/bht_upd_fifo.sv
// Synchronous FIFO of pending BHT counter updates.
// Pointers carry one extra wrap bit to tell full from empty.
module bht_upd_fifo
   import bpb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     flush_i,
   input  logic     push_i,
   input  bht_upd_t data_i,
   input  logic     pop_i,
   output bht_upd_t head_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   bht_upd_t    mem_q [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/state_switch.sv
// 2-bit saturating branch counter step.
// Taken moves toward strong-taken, not-taken toward strong-not-taken.
module state_switch
   import bpb_pkg::*;
(
   input  logic [1:0] state_i,
   input  logic       taken_i,
   output logic [1:0] state_o
);

   always_comb begin
      state_o = state_i;
      if (taken_i) begin
         if (state_i != CNT_STRONG_T) state_o = state_i + 2'd1;
      end else begin
         if (state_i != CNT_STRONG_NT) state_o = state_i - 2'd1;
      end
   end

endmodule

// File: rtl/bht_arbiter.sv
// Shares the single BHT port between fetch lookups and
// queued commit updates (two-cycle read-modify-write), plus table clear.
module bht_arbiter
   import bpb_pkg::*;
#(
   parameter int SIZE_WIDTH = BPB_E,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  lookup_valid_i,
   input  logic [SIZE_WIDTH-1:0] lookup_index_i,
   output logic                  lookup_ready_o,
   output logic                  pred_valid_o,
   output logic [1:0]            pred_o,
   input  logic                  upd_valid_i,
   input  logic [SIZE_WIDTH-1:0] upd_index_i,
   input  logic                  upd_taken_i,
   output logic                  upd_ready_o,
   output logic                  tbl_en_o,
   output logic                  tbl_we_o,
   output logic [SIZE_WIDTH-1:0] tbl_addr_o,
   output logic [1:0]            tbl_wdata_o,
   input  logic [1:0]            tbl_rdata_i,
   output logic                  busy_o
);

   localparam logic [SIZE_WIDTH-1:0] CLR_LAST = '1;

   bht_state_e            state_q;
   logic [SIZE_WIDTH-1:0] clr_cnt_q;
   logic                  pred_valid_q;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic                  lookup_fire;
   bht_upd_t              push_data;
   bht_upd_t              head;
   logic [SIZE_WIDTH-1:0] head_idx;
   logic [1:0]            cnt_next;

   assign lookup_ready_o = (state_q == IDLE) && !fifo_full;
   assign upd_ready_o    = (state_q != INIT) && !fifo_full;
   assign lookup_fire    = lookup_valid_i && lookup_ready_o && !flush_i;
   assign push           = upd_valid_i && upd_ready_o && !flush_i;
   assign pop            = (state_q == RMW_WR) && !flush_i;
   assign busy_o         = (state_q == INIT);

   assign push_data.index = BPB_E'(upd_index_i);
   assign push_data.taken = upd_taken_i;
   assign head_idx        = SIZE_WIDTH'(head.index);

   assign pred_valid_o = pred_valid_q && !flush_i;
   assign pred_o       = pred_valid_o ? tbl_rdata_i : CNT_STRONG_NT;

   bht_upd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   state_switch u_cnt (
      .state_i (tbl_rdata_i),
      .taken_i (head.taken),
      .state_o (cnt_next)
   );

   // A flushed RMW or clear step must not touch the table.
   always_comb begin
      tbl_en_o    = 1'b0;
      tbl_we_o    = 1'b0;
      tbl_addr_o  = '0;
      tbl_wdata_o = CNT_STRONG_NT;
      unique case (state_q)
         INIT: begin
            tbl_en_o   = 1'b1;
            tbl_we_o   = !rst_i && !flush_i;
            tbl_addr_o = clr_cnt_q;
         end
         IDLE: begin
            tbl_en_o   = lookup_fire;
            tbl_addr_o = lookup_fire ? lookup_index_i : '0;
         end
         RMW_RD: begin
            tbl_en_o   = !flush_i;
            tbl_addr_o = head_idx;
         end
         RMW_WR: begin
            tbl_en_o    = !flush_i;
            tbl_we_o    = !flush_i;
            tbl_addr_o  = head_idx;
            tbl_wdata_o = cnt_next;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= INIT;
         clr_cnt_q    <= '0;
         pred_valid_q <= 1'b0;
      end else if (flush_i) begin
         state_q      <= INIT;
         clr_cnt_q    <= '0;
         pred_valid_q <= 1'b0;
      end else begin
         pred_valid_q <= lookup_fire;
         unique case (state_q)
            INIT: begin
               clr_cnt_q <= clr_cnt_q + 1'b1;
               if (clr_cnt_q == CLR_LAST) state_q <= IDLE;
            end
            IDLE: begin
               // an update arriving now starts its RMW next cycle
               if (fifo_full)
                  state_q <= RMW_RD;
               else if (lookup_valid_i)
                  state_q <= IDLE;
               else if (!fifo_empty || push)
                  state_q <= RMW_RD;
            end
            RMW_RD: state_q <= RMW_WR;
            RMW_WR: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bht_arbiter.sv
// Directed bench for bht_arbiter with a 16-entry table model.
// Inputs change 1ns after posedge; outputs checked on negedge.
module tb_bht_arbiter;

   logic       clk;
   logic       rst;
   logic       flush;
   logic       lv;
   logic [3:0] li;
   logic       lookup_ready;
   logic       pred_valid;
   logic [1:0] pred;
   logic       uv;
   logic [3:0] ui;
   logic       ut;
   logic       upd_ready;
   logic       tbl_en;
   logic       tbl_we;
   logic [3:0] tbl_addr;
   logic [1:0] tbl_wdata;
   logic [1:0] tbl_rdata;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;

   logic [1:0] mem [16];

   bht_arbiter #(
      .SIZE_WIDTH (4),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .flush_i        (flush),
      .lookup_valid_i (lv),
      .lookup_index_i (li),
      .lookup_ready_o (lookup_ready),
      .pred_valid_o   (pred_valid),
      .pred_o         (pred),
      .upd_valid_i    (uv),
      .upd_index_i    (ui),
      .upd_taken_i    (ut),
      .upd_ready_o    (upd_ready),
      .tbl_en_o       (tbl_en),
      .tbl_we_o       (tbl_we),
      .tbl_addr_o     (tbl_addr),
      .tbl_wdata_o    (tbl_wdata),
      .tbl_rdata_i    (tbl_rdata),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tbl_en) begin
         if (tbl_we) mem[tbl_addr] <= tbl_wdata;
         else        tbl_rdata <= mem[tbl_addr];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr_chk(input string tag, input logic [3:0] a,
                         input logic [1:0] d);
      chk({tag, "_we"}, tbl_we, 1);
      chk({tag, "_addr"}, tbl_addr, a);
      chk({tag, "_wdata"}, tbl_wdata, d);
   endtask

   task automatic init_seq(input string tag);
      for (int i = 0; i < 16; i++) begin
         mid();
         chk({tag, "_busy"}, busy, 1);
         wr_chk(tag, 4'(i), 2'b00);
         cyc();
      end
      mid();
      chk({tag, "_busy_done"}, busy, 0);
      chk({tag, "_lrdy"}, lookup_ready, 1);
      chk({tag, "_urdy"}, upd_ready, 1);
      cyc();
   endtask

   task automatic do_lookup(input logic [3:0] idx, input logic [1:0] exp,
                            input string tag);
      int n;
      n = 0;
      lv = 1'b1;
      li = idx;
      mid();
      while (!lookup_ready && n < 20) begin
         cyc();
         mid();
         n++;
      end
      chk({tag, "_rdy"}, lookup_ready, 1);
      cyc();
      lv = 1'b0;
      mid();
      chk({tag, "_pv"}, pred_valid, 1);
      chk(tag, pred, exp);
      cyc();
      mid();
      chk({tag, "_pv_drop"}, pred_valid, 0);
      cyc();
   endtask

   task automatic do_update(input logic [3:0] idx, input logic tk,
                            input string tag);
      int n;
      n = 0;
      uv = 1'b1;
      ui = idx;
      ut = tk;
      mid();
      while (!upd_ready && n < 20) begin
         cyc();
         mid();
         n++;
      end
      chk({tag, "_urdy"}, upd_ready, 1);
      cyc();
      uv = 1'b0;
      repeat (4) cyc();
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      lv = 1'b0;
      li = '0;
      uv = 1'b0;
      ui = '0;
      ut = 1'b0;

      repeat (2) @(posedge clk);
      mid();
      chk("rst_busy", busy, 1);
      chk("rst_en", tbl_en, 1);
      chk("rst_we", tbl_we, 0);
      chk("rst_addr", tbl_addr, 0);
      chk("rst_wdata", tbl_wdata, 0);
      chk("rst_lrdy", lookup_ready, 0);
      chk("rst_urdy", upd_ready, 0);
      chk("rst_pv", pred_valid, 0);
      chk("rst_pred", pred, 0);
      cyc();
      rst = 1'b0;

      init_seq("init");
      do_lookup(4'd5, 2'b00, "lk5_clear");

      // first update: check RMW timing explicitly
      uv = 1'b1;
      ui = 4'd3;
      ut = 1'b1;
      mid();
      chk("u3_urdy", upd_ready, 1);
      cyc();
      uv = 1'b0;
      mid();
      chk("u3_rd_en", tbl_en, 1);
      chk("u3_rd_we", tbl_we, 0);
      chk("u3_rd_addr", tbl_addr, 3);
      cyc();
      mid();
      wr_chk("u3_wr", 4'd3, 2'b01);
      cyc();
      mid();
      chk("u3_idle_en", tbl_en, 0);
      cyc();
      do_lookup(4'd3, 2'b01, "sat_01");
      do_update(4'd3, 1'b1, "sat_u2");
      do_lookup(4'd3, 2'b10, "sat_10");
      do_update(4'd3, 1'b1, "sat_u3");
      do_lookup(4'd3, 2'b11, "sat_11");
      do_update(4'd3, 1'b1, "sat_u4");
      do_lookup(4'd3, 2'b11, "sat_hold");
      do_update(4'd3, 1'b0, "sat_n1");
      do_lookup(4'd3, 2'b10, "sat_dn10");
      do_update(4'd3, 1'b0, "sat_n2");
      do_lookup(4'd3, 2'b01, "sat_dn01");

      // fill the FIFO while lookups hog the port
      lv = 1'b1;
      li = 4'd0;
      for (int k = 0; k < 4; k++) begin
         uv = 1'b1;
         ui = 4'(10 + k);
         ut = 1'b1;
         mid();
         chk("fill_urdy", upd_ready, 1);
         chk("fill_lrdy", lookup_ready, 1);
         cyc();
      end
      uv = 1'b0;
      mid();
      chk("full_lrdy", lookup_ready, 0);
      chk("full_urdy", upd_ready, 0);
      chk("full_en", tbl_en, 0);
      cyc();
      mid();
      chk("full_rd_en", tbl_en, 1);
      chk("full_rd_we", tbl_we, 0);
      chk("full_rd_addr", tbl_addr, 10);
      chk("full_rd_lrdy", lookup_ready, 0);
      cyc();
      uv = 1'b1;
      ui = 4'd14;
      ut = 1'b1;
      mid();
      wr_chk("full_wr", 4'd10, 2'b01);
      chk("full_wr_urdy", upd_ready, 0);
      chk("full_wr_lrdy", lookup_ready, 0);
      cyc();
      uv = 1'b0;
      mid();
      chk("resume_lrdy", lookup_ready, 1);
      chk("resume_en", tbl_en, 1);
      chk("resume_we", tbl_we, 0);
      chk("resume_addr", tbl_addr, 0);
      cyc();
      lv = 1'b0;
      repeat (12) cyc();
      do_lookup(4'd10, 2'b01, "fill_10");
      do_lookup(4'd13, 2'b01, "fill_13");
      do_lookup(4'd14, 2'b00, "no_bypass_14");

      // push during the pop of RMW_WR at occupancy 2
      lv = 1'b1;
      li = 4'd1;
      uv = 1'b1;
      ui = 4'd7;
      ut = 1'b1;
      cyc();
      ui = 4'd8;
      cyc();
      lv = 1'b0;
      uv = 1'b0;
      mid();
      chk("pp_idle_en", tbl_en, 0);
      cyc();
      mid();
      chk("pp_rd7", tbl_addr, 7);
      chk("pp_rd7_we", tbl_we, 0);
      cyc();
      uv = 1'b1;
      ui = 4'd9;
      mid();
      chk("pp_push_urdy", upd_ready, 1);
      wr_chk("pp_wr7", 4'd7, 2'b01);
      cyc();
      uv = 1'b0;
      mid();
      chk("pp_idle2_en", tbl_en, 0);
      cyc();
      mid();
      chk("pp_rd8", tbl_addr, 8);
      cyc();
      mid();
      wr_chk("pp_wr8", 4'd8, 2'b01);
      cyc();
      cyc();
      mid();
      chk("pp_rd9", tbl_addr, 9);
      cyc();
      mid();
      wr_chk("pp_wr9", 4'd9, 2'b01);
      cyc();
      mid();
      chk("pp_empty_en", tbl_en, 0);
      cyc();

      // flush while an RMW is reading
      uv = 1'b1;
      ui = 4'd6;
      ut = 1'b1;
      cyc();
      uv = 1'b0;
      flush = 1'b1;
      mid();
      chk("fl_we", tbl_we, 0);
      chk("fl_pv", pred_valid, 0);
      cyc();
      flush = 1'b0;
      init_seq("reinit");
      mid();
      chk("fl_fifo_empty", tbl_en, 0);
      cyc();
      do_lookup(4'd6, 2'b00, "fl_lk6");
      do_lookup(4'd3, 2'b00, "fl_lk3");

      // back-to-back updates to one index
      do_update(4'd2, 1'b1, "b2b_seed");
      uv = 1'b1;
      ui = 4'd2;
      ut = 1'b1;
      cyc();
      mid();
      chk("b2b_urdy2", upd_ready, 1);
      chk("b2b_rd", tbl_addr, 2);
      cyc();
      uv = 1'b0;
      mid();
      wr_chk("b2b_wr1", 4'd2, 2'b10);
      cyc();
      cyc();
      mid();
      chk("b2b_rd2", tbl_addr, 2);
      cyc();
      mid();
      wr_chk("b2b_wr2", 4'd2, 2'b11);
      cyc();
      do_lookup(4'd2, 2'b11, "b2b_final");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
